// File: rtl/cost_rom_pkg.sv
// Shared widths, types and the in-flight lookup tag for the cost ROM arbiter.
package cost_rom_pkg;
    localparam int IDX_W     = 3;
    localparam int COST_W    = 7;
    localparam int CNT_W     = 16;
    localparam int N_CLIENTS = 2;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [COST_W-1:0] cost_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef struct packed {
        logic valid;
        logic client;
        idx_t w;
        idx_t j;
    } tag_t;
endpackage

// File: rtl/cost_rom_arb_if.sv
// Client, ROM and counter signals of the two-client cost ROM arbiter.
interface cost_rom_arb_if;
    import cost_rom_pkg::*;

    logic  req0, req1;
    idx_t  w0, w1;
    idx_t  j0, j1;
    logic  lock0, lock1;
    logic  gnt0, gnt1;
    logic  rvalid0, rvalid1;
    cost_t rdata0, rdata1;
    idx_t  W, J;
    cost_t Cost;
    cnt_t  gcnt0, gcnt1;

    modport slave (
        input  req0, req1, w0, w1, j0, j1, lock0, lock1, Cost,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, W, J, gcnt0, gcnt1
    );

    modport master (
        output req0, req1, w0, w1, j0, j1, lock0, lock1, Cost,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, W, J, gcnt0, gcnt1
    );
endinterface

// File: rtl/cost_rom_arb_rr_arb2.sv
// Two-way round-robin arbiter; with COST_ROM_ARB_LOCK_EN a locked grant makes
// its client the owner with absolute priority until its lock drops.
module rr_arb2
    import cost_rom_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_CLIENTS-1:0] req,
    input  logic [N_CLIENTS-1:0] lock,
    output logic [N_CLIENTS-1:0] gnt
);
    logic ptr;      // client that wins a tie
    logic own_act;  // an owner exists and still holds its lock this cycle
    logic owner;

`ifdef COST_ROM_ARB_LOCK_EN
    logic own_vld;

    assign own_act = own_vld & lock[owner];

    always_ff @(posedge CLK) begin
        if (RST) begin
            own_vld <= 1'b0;
            owner   <= 1'b0;
        end else if (gnt[0] && lock[0]) begin
            own_vld <= 1'b1;
            owner   <= 1'b0;
        end else if (gnt[1] && lock[1]) begin
            own_vld <= 1'b1;
            owner   <= 1'b1;
        end else if (!own_act) begin
            own_vld <= 1'b0;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign own_act     = 1'b0;
    assign owner       = 1'b0;
`endif

    always_comb begin
        gnt = '0;
        if (RST) begin
            gnt = '0;
        end else if (own_act) begin
            // owner that dropped req still blocks the other client
            gnt[owner] = req[owner];
        end else if (req[0] && req[1]) begin
            gnt[ptr] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            ptr <= 1'b0;
        else if (|gnt)
            ptr <= gnt[0];
    end
endmodule

// File: rtl/cost_rom_arb.sv
// Two-client cost ROM arbiter: grant, drive W/J for one cycle, return Cost
// two cycles after the grant. Optional lock feature: COST_ROM_ARB_LOCK_EN.
module cost_rom_arb
    import cost_rom_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    cost_rom_arb_if.slave  bus
);
    logic [N_CLIENTS-1:0] req_vec;
    logic [N_CLIENTS-1:0] lock_vec;
    logic [N_CLIENTS-1:0] gnt_vec;

    assign req_vec  = {bus.req1, bus.req0};
    assign lock_vec = {bus.lock1, bus.lock0};

    rr_arb2 u_arb (
        .CLK  (CLK),
        .RST  (RST),
        .req  (req_vec),
        .lock (lock_vec),
        .gnt  (gnt_vec)
    );

    assign bus.gnt0 = gnt_vec[0];
    assign bus.gnt1 = gnt_vec[1];

    // grant -> ROM address stage; w/j hold when nothing is granted
    tag_t tag_p0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_p0 <= '0;
        end else begin
            tag_p0.valid <= |gnt_vec;
            if (gnt_vec[1]) begin
                tag_p0.client <= 1'b1;
                tag_p0.w      <= bus.w1;
                tag_p0.j      <= bus.j1;
            end else if (gnt_vec[0]) begin
                tag_p0.client <= 1'b0;
                tag_p0.w      <= bus.w0;
                tag_p0.j      <= bus.j0;
            end
        end
    end

    assign bus.W = tag_p0.w;
    assign bus.J = tag_p0.j;

    // ROM data -> client response stage
    logic [N_CLIENTS-1:0] vld_p1;
    cost_t                rdata_p1 [N_CLIENTS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1 <= '0;
            for (int i = 0; i < N_CLIENTS; i++)
                rdata_p1[i] <= '0;
        end else begin
            vld_p1[0] <= tag_p0.valid & ~tag_p0.client;
            vld_p1[1] <= tag_p0.valid &  tag_p0.client;
            if (tag_p0.valid)
                rdata_p1[tag_p0.client] <= bus.Cost;
        end
    end

    assign bus.rvalid0 = vld_p1[0];
    assign bus.rvalid1 = vld_p1[1];
    assign bus.rdata0  = rdata_p1[0];
    assign bus.rdata1  = rdata_p1[1];

    cnt_t gcnt [N_CLIENTS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_CLIENTS; i++)
                gcnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++)
                if (gnt_vec[i])
                    gcnt[i] <= gcnt[i] + cnt_t'(1);
        end
    end

    assign bus.gcnt0 = gcnt[0];
    assign bus.gcnt1 = gcnt[1];
endmodule

// File: tb/tb_cost_rom_arb.sv
// Bench for cost_rom_arb: directed literal cases plus random traffic checked
// every cycle against a transaction-level model; ROM is Cost = 8*W + J.
module tb_cost_rom_arb;
    import cost_rom_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    cost_rom_arb_if bus();

    cost_rom_arb dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    assign bus.Cost = 7'(8 * int'(bus.W) + int'(bus.J));

    int nchecks = 0;
    int nfail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int due;
        int client;
        int cost;
    } resp_t;

    resp_t       pend[$];
    int          last_g;
    int          owner;
    logic [15:0] m_cnt   [2];
    logic [6:0]  m_rdata [2];
    logic [2:0]  m_w, m_j;
    int          cyc;
    bit          live;

    initial begin
        live   = 0;
        cyc    = 0;
        last_g = 1;
        owner  = -1;
        forever begin
            @(negedge CLK);
            begin : model_step
                int g;
                bit locked;
                bit [1:0] req;
                bit [1:0] lk;
                bit rv [2];
                req    = {bus.req1, bus.req0};
                lk     = {bus.lock1, bus.lock0};
                g      = -1;
                locked = 0;
                rv[0]  = 0;
                rv[1]  = 0;
                if (!RST) begin
`ifdef COST_ROM_ARB_LOCK_EN
                    if (owner >= 0 && !lk[owner]) owner = -1;
                    locked = (owner >= 0);
                    if (locked && req[owner]) g = owner;
`endif
                    if (!locked) begin
                        if (req == 2'b11)   g = 1 - last_g;
                        else if (req[0])    g = 0;
                        else if (req[1])    g = 1;
                    end
                end
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    rv[pend[0].client]      = 1;
                    m_rdata[pend[0].client] = 7'(pend[0].cost);
                    void'(pend.pop_front());
                end
                if (live) begin
                    chk("gnt0",    32'(bus.gnt0),    32'(g == 0));
                    chk("gnt1",    32'(bus.gnt1),    32'(g == 1));
                    chk("rvalid0", 32'(bus.rvalid0), 32'(rv[0]));
                    chk("rvalid1", 32'(bus.rvalid1), 32'(rv[1]));
                    chk("rdata0",  32'(bus.rdata0),  32'(m_rdata[0]));
                    chk("rdata1",  32'(bus.rdata1),  32'(m_rdata[1]));
                    chk("W",       32'(bus.W),       32'(m_w));
                    chk("J",       32'(bus.J),       32'(m_j));
                    chk("gcnt0",   32'(bus.gcnt0),   32'(m_cnt[0]));
                    chk("gcnt1",   32'(bus.gcnt1),   32'(m_cnt[1]));
                end
                if (RST) begin
                    live       = 1;
                    last_g     = 1;
                    owner      = -1;
                    pend.delete();
                    m_w        = '0;
                    m_j        = '0;
                    m_cnt[0]   = '0;
                    m_cnt[1]   = '0;
                    m_rdata[0] = '0;
                    m_rdata[1] = '0;
                end else if (g >= 0) begin
                    m_w = (g == 0) ? bus.w0 : bus.w1;
                    m_j = (g == 0) ? bus.j0 : bus.j1;
                    pend.push_back('{cyc + 2, g, 8 * int'(m_w) + int'(m_j)});
                    m_cnt[g] = m_cnt[g] + 16'd1;
                    last_g   = g;
`ifdef COST_ROM_ARB_LOCK_EN
                    if (lk[g]) owner = g;
`endif
                end
                cyc++;
            end
        end
    end

    // ---------------- stimulus with literal expectations ----------------
    initial begin
        bus.req0 = 1'b1; bus.req1 = 1'b0;
        bus.w0 = '0; bus.j0 = '0; bus.w1 = '0; bus.j1 = '0;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        RST = 1'b1;

        tick();
        @(negedge CLK);
        chk("rst_gnt0",    32'(bus.gnt0),    32'd0);
        chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("rst_W",       32'(bus.W),       32'd0);
        chk("rst_gcnt0",   32'(bus.gcnt0),   32'd0);
        tick();
        tick();

        // single request: w=3, j=5 -> cost 29 two cycles later
        RST = 1'b0; bus.req0 = 1'b1; bus.w0 = 3'd3; bus.j0 = 3'd5;
        @(negedge CLK);
        chk("single_gnt0", 32'(bus.gnt0), 32'd1);
        chk("single_gnt1", 32'(bus.gnt1), 32'd0);
        tick();
        bus.req0 = 1'b0;
        @(negedge CLK);
        chk("single_W", 32'(bus.W), 32'd3);
        chk("single_J", 32'(bus.J), 32'd5);
        tick();
        @(negedge CLK);
        chk("single_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("single_rdata0",  32'(bus.rdata0),  32'd29);
        chk("single_gcnt0",   32'(bus.gcnt0),   32'd1);
        tick();

        // one grant to client 1 so client 0 has the tie next
        bus.req1 = 1'b1; bus.w1 = 3'd0; bus.j1 = 3'd0;
        tick();
        bus.req1 = 1'b0;
        repeat (3) tick();

        // both requesting for four cycles: 0,1,0,1 with back-to-back responses
        bus.req0 = 1'b1; bus.w0 = 3'd1; bus.j0 = 3'd0;
        bus.req1 = 1'b1; bus.w1 = 3'd2; bus.j1 = 3'd7;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k < 4) begin
                chk("rr_gnt0", 32'(bus.gnt0), 32'(k % 2 == 0));
                chk("rr_gnt1", 32'(bus.gnt1), 32'(k % 2 == 1));
            end
            if (k >= 2) begin
                chk("rr_rvalid0", 32'(bus.rvalid0), 32'(k % 2 == 0));
                chk("rr_rvalid1", 32'(bus.rvalid1), 32'(k % 2 == 1));
                if (k % 2 == 0) chk("rr_rdata0", 32'(bus.rdata0), 32'd8);
                else            chk("rr_rdata1", 32'(bus.rdata1), 32'd23);
            end
            tick();
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        repeat (2) tick();

        // lock0 held for five cycles, then released
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.lock0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bit exp0;
            if (k == 5) bus.lock0 = 1'b0;
`ifdef COST_ROM_ARB_LOCK_EN
            exp0 = (k < 5);
`else
            exp0 = (k < 5) && (k % 2 == 0);
`endif
            @(negedge CLK);
            chk("lock_gnt0", 32'(bus.gnt0), 32'(exp0));
            chk("lock_gnt1", 32'(bus.gnt1), 32'(!exp0));
            tick();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (3) tick();

        // reset the cycle after a grant: lookup dropped, pointer back to 0
        bus.req0 = 1'b1; bus.w0 = 3'd6; bus.j0 = 3'd6;
        tick();
        RST = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b1;
        @(negedge CLK);
        chk("rsthold_gnt1", 32'(bus.gnt1), 32'd0);
        tick();
        @(negedge CLK);
        chk("midrst_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("midrst_rdata0",  32'(bus.rdata0),  32'd0);
        chk("midrst_W",       32'(bus.W),       32'd0);
        chk("midrst_J",       32'(bus.J),       32'd0);
        chk("midrst_gcnt0",   32'(bus.gcnt0),   32'd0);
        chk("midrst_gcnt1",   32'(bus.gcnt1),   32'd0);
        tick();
        RST = 1'b0; bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge CLK);
        chk("postrst_gnt0",    32'(bus.gnt0),    32'd1);
        chk("postrst_rvalid0", 32'(bus.rvalid0), 32'd0);
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (3) tick();

        // random traffic, locks and occasional resets
        for (int n = 0; n < 3000; n++) begin
            bus.req0  = ($urandom_range(0, 99) < 60);
            bus.req1  = ($urandom_range(0, 99) < 60);
            bus.lock0 = ($urandom_range(0, 99) < 40);
            bus.lock1 = ($urandom_range(0, 99) < 40);
            bus.w0 = 3'($urandom); bus.j0 = 3'($urandom);
            bus.w1 = 3'($urandom); bus.j1 = 3'($urandom);
            RST = ($urandom_range(0, 199) == 0);
            tick();
        end

        // counter wrap: 65536 grants to client 1 from a clean reset
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0; bus.req1 = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            if (i == 65535) begin
                @(negedge CLK);
                chk("wrap_gcnt1_max", 32'(bus.gcnt1), 32'h0000_FFFF);
            end
            tick();
        end
        bus.req1 = 1'b0;
        @(negedge CLK);
        chk("wrap_gcnt1", 32'(bus.gcnt1), 32'd0);
        chk("wrap_gcnt0", 32'(bus.gcnt0), 32'd0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule

// File: doc/cost_rom_arb.md
COST_ROM_ARB -- requirements
Module: cost_rom_arb

Interface
REQ-001 The block SHALL use clock CLK and reset RST, synchronous, active-high; all state SHALL update on posedge CLK.
REQ-002 The block SHALL have these ports:
  CLK        in   1  clock
  RST        in   1  synchronous active-high reset
  req0/req1  in   1  client n requests one cost lookup; held until granted
  w0/w1      in   3  client n worker index
  j0/j1      in   3  client n job index
  lock0/lock1 in  1  client n asks to keep the port after its current grant
  gnt0/gnt1  out  1  combinational; request accepted this cycle
  rvalid0/rvalid1 out 1  registered; rdata valid for one cycle
  rdata0/rdata1 out 7  registered cost returned to client n
  W          out  3  registered worker index to cost ROM
  J          out  3  registered job index to cost ROM
  Cost       in   7  ROM data; combinational from W,J, same cycle
  gcnt0/gcnt1 out 16 registered grant counters
REQ-003 The block SHALL have no parameters; all widths SHALL come from the shared package.

Function
REQ-004 At most one of gnt0/gnt1 SHALL be high per cycle, and gntn SHALL be high only while reqn is high.
REQ-005 Arbitration SHALL be round-robin: with both requesting, grant goes to the client not granted most recently; a single requester SHALL be granted the same cycle.
REQ-006 The priority pointer SHALL reset to client 0 and SHALL update only on cycles with a grant.
REQ-007 On a grant in cycle t, W/J SHALL hold the granted wn/jn during cycle t+1.
REQ-008 Cost SHALL be sampled at the end of cycle t+1, and rdatan/rvalidn of the granted client SHALL be driven during cycle t+2 (fixed latency 2).
REQ-009 The pipeline SHALL accept one request per cycle; back-to-back grants SHALL produce back-to-back rvalid pulses in grant order with no bubbles.
REQ-010 With no grant in cycle t, W/J SHALL hold their previous values and no rvalid SHALL occur at t+2.
REQ-011 rvalid0 and rvalid1 SHALL never be high in the same cycle.
REQ-012 A client deasserting req before grant SHALL be legal; no response SHALL be generated for it.
REQ-013 gcntn SHALL increment on each gntn and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-014 On RST the block SHALL drive: gnt* 0, rvalid* 0, rdata* 0, W 0, J 0, gcnt* 0, pointer to client 0, lock owner none.
REQ-015 Reset asserted mid-operation SHALL discard all in-flight lookups, and no rvalid SHALL appear after RST deasserts until a new grant completes.
REQ-016 While RST is high, gnt0/gnt1 SHALL be 0 regardless of req.

Configuration
REQ-017 With macro COST_ROM_ARB_LOCK_EN defined: a client granted while its lock is high SHALL become lock owner and have absolute priority; ownership SHALL end on the first cycle its lock is low.
REQ-018 With COST_ROM_ARB_LOCK_EN undefined, lock0/lock1 SHALL remain as ports but SHALL be ignored, and arbitration SHALL be pure round-robin.
REQ-019 A lock owner that drops req while keeping lock high SHALL NOT be granted, and the other client SHALL still be blocked.

Structure
REQ-020 Package cost_rom_pkg SHALL hold IDX_W=3, COST_W=7, CNT_W=16, N_CLIENTS=2, typedefs idx_t and cost_t, and the pipeline tag struct {valid, client, w, j}.
REQ-021 The round-robin grant logic (pointer plus lock owner) SHALL be a sub-module rr_arb2; the datapath pipeline and counters SHALL live in cost_rom_arb.

Verification (bench ROM: Cost = 8*W+J)
REQ-022 Only req0 with w0=3, j0=5 at cycle t -> gnt0 at t, W=3 and J=5 at t+1, rvalid0 with rdata0=29 at t+2, gcnt0=1.
REQ-023 req0 and req1 both held for 4 cycles, w0=1/j0=0 and w1=2/j1=7 -> grants 0,1,0,1; rdata 8,23,8,23 on alternating rvalid0/rvalid1 with no gaps.
REQ-024 Grant issued at t, RST high at t+1 -> no rvalid at t+2 or later; all outputs 0; first post-reset grant goes to client 0.
REQ-025 With COST_ROM_ARB_LOCK_EN and lock0 high, both requesting for 5 cycles -> 5 grants to client 0; lock0 drops -> next grant to client 1. Without the macro -> alternating grants.
REQ-026 Force 65536 grants to client 1 -> gcnt1 wraps to 0, gcnt0 unchanged.
